// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detection run controller.
//   - Default sizes for pattern length, match/target counters and timeout timer.
//   - LEN_W: width needed to hold a pattern length of 0..DEF_MAX_LEN.
//   - state_e: controller state encoding (IDLE, RUN).
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TO_W    = 16;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Bit-level matcher: shifts accepted serial bits into a history register,
// tracks how many bits are usable (bits_seen, saturating at MAX_LEN) and
// compares the newest len bits against the pattern.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : job load; clears history and bits_seen
//   accept_i     : a bit is accepted this cycle (data_valid in RUN, no abort)
//   data_i       : the serial bit being accepted
//   pattern_i    : latched pattern, bit 0 = newest bit
//   len_i        : latched pattern length (1..MAX_LEN)
//   overlap_i    : 1 = keep history after a match
//   hit_o        : combinational; the accepted bit completes a match
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               accept_i,
    input  logic               data_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   seen_q, seen_d;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   seen_next;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    // Compare is done on the post-shift view so the hit is known in the
    // same cycle the completing bit is accepted.
    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], data_i};
        seen_next = (seen_q == LEN_W'(MAX_LEN)) ? seen_q : seen_q + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
        hit = accept_i && (seen_next >= len_i) &&
              ((hist_next & mask) == (pattern_i & mask));
    end

    assign hit_o = hit;

    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (clear_i) begin
            hist_d = '0;
            seen_d = '0;
        end else if (accept_i) begin
            hist_d = hist_next;
            // Non-overlapping mode: restart the bit count so stale history
            // cannot contribute to the next match.
            seen_d = (hit && !overlap_i) ? '0 : seen_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for programmable serial pattern detection.
// A job (pattern, length, overlap mode, target count, timeout) is latched
// on start; valid-qualified bits are scanned in RUN, matches counted, and
// the job ends on target reached, timeout or abort.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : job request, accepted only in IDLE
//   abort           : cancel, honoured in any state, no strobes
//   cfg_pattern/len/overlap/target/timeout : job configuration
//   data_valid, data_in : serial input stream
//   busy            : high while in RUN
//   match_pulse     : one-cycle strobe per match
//   match_count     : matches in current/last job (saturating)
//   done            : strobe, target reached (with final match_pulse)
//   timed_out       : strobe, cycle budget exhausted
//   cfg_err         : strobe, start rejected for bad cfg_len
// Priority within a cycle: abort > match > timeout.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic [TO_W-1:0]              cfg_timeout,
    input  logic                         data_valid,
    input  logic                         data_in,
    output logic                         busy,
    output logic                         match_pulse,
    output logic [CNT_W-1:0]             match_count,
    output logic                         done,
    output logic                         timed_out,
    output logic                         cfg_err
);

    localparam int LW = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               pulse_q, pulse_d;
    logic               done_q, done_d;
    logic               to_q, to_d;
    logic               err_q, err_d;

    logic               load;
    logic               accept;
    logic               hit;
    logic               len_ok;
    logic               to_hit;
    logic               final_hit;
    logic [CNT_W:0]     count_p1;

    assign accept = (state_q == ST_RUN) && data_valid && !abort;

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LW)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (load),
        .accept_i  (accept),
        .data_i    (data_in),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .overlap_i (overlap_q),
        .hit_o     (hit)
    );

    always_comb begin
        len_ok    = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
        to_hit    = (timeout_q != '0) && (timer_q == timeout_q - TO_W'(1));
        // One extra bit so a saturated count can never alias a target value.
        count_p1  = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
        final_hit = hit && (target_q != '0) && (count_p1 == {1'b0, target_q});
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        timeout_d = timeout_q;
        timer_d   = timer_q;
        count_d   = count_q;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        to_d      = 1'b0;
        err_d     = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    if (len_ok) begin
                        load      = 1'b1;
                        state_d   = ST_RUN;
                        pattern_d = cfg_pattern;
                        len_d     = cfg_len;
                        overlap_d = cfg_overlap;
                        target_d  = cfg_target;
                        timeout_d = cfg_timeout;
                        timer_d   = '0;
                        count_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                    if (hit) begin
                        pulse_d = 1'b1;
                        count_d = (count_q == '1) ? count_q : count_p1[CNT_W-1:0];
                        if (final_hit) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    // A final match in the same cycle wins over the timeout.
                    if (to_hit && !final_hit) begin
                        to_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            timeout_q <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            pulse_q   <= pulse_d;
            done_q    <= done_d;
            to_q      <= to_d;
            err_q     <= err_d;
        end
    end

    assign busy        = busy_q;
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign timed_out   = to_q;
    assign cfg_err     = err_q;

endmodule
